// File: rtl/branch_predict_unit.sv
// Branch direction unit: EX condition decode, 2-bit counter predictor,
// registered mispredict pulse and saturating performance counters.
module branch_predict_unit #(
  parameter int         ENTRIES    = 64,
  parameter int         PC_WIDTH   = 32,
  parameter int         STAT_WIDTH = 16,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   if_pc,
  output logic                  pred_taken,
  input  logic                  ex_valid,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic [2:0]            ex_branch_src,
  input  logic                  zero,
  input  logic                  neg,
  input  logic                  negu,
  input  logic                  ex_pred_taken,
  output logic                  ex_taken,
  output logic                  mispredict,
  output logic                  mispredict_taken,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);

  logic [1:0]     tbl [ENTRIES];
  logic [IDX-1:0] if_idx;
  logic [IDX-1:0] ex_idx;
  logic [1:0]     ex_ctr;
  logic           is_branch;
  logic           miss;
  logic           unused_pc;

  assign if_idx     = if_pc[IDX+1:2];
  assign ex_idx     = ex_pc[IDX+1:2];
  assign ex_ctr     = tbl[ex_idx];
  assign pred_taken = tbl[if_idx][1];

  // Only the index bits of either PC feed the table.
  assign unused_pc = ^{if_pc[PC_WIDTH-1:IDX+2], if_pc[1:0],
                       ex_pc[PC_WIDTH-1:IDX+2], ex_pc[1:0]};

  always_comb begin
    ex_taken = 1'b0;
    unique case (ex_branch_src)
      3'b000: ex_taken = 1'b0;
      3'b001: ex_taken = zero;
      3'b010: ex_taken = ~zero;
      3'b011: ex_taken = neg;
      3'b100: ex_taken = ~neg | zero;
      3'b101: ex_taken = negu;
      3'b110: ex_taken = ~negu | zero;
      3'b111: ex_taken = 1'b0;
    endcase
  end

  assign is_branch = ex_valid
                   & (ex_branch_src != 3'b000)
                   & (ex_branch_src != 3'b111);
  assign miss      = is_branch & (ex_taken ^ ex_pred_taken);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= INIT_STATE;
      end
    end else if (is_branch) begin
      if (ex_taken && ex_ctr != 2'b11) begin
        tbl[ex_idx] <= ex_ctr + 2'd1;
      end else if (!ex_taken && ex_ctr != 2'b00) begin
        tbl[ex_idx] <= ex_ctr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict       <= 1'b0;
      mispredict_taken <= 1'b0;
    end else begin
      mispredict <= miss;
      if (is_branch) begin
        mispredict_taken <= ex_taken;
      end
    end
  end

  // Clear wins over a coincident increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clear) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (is_branch && stat_branches != '1) begin
        stat_branches <= stat_branches + 1'b1;
      end
      if (miss && stat_mispredicts != '1) begin
        stat_mispredicts <= stat_mispredicts + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit against a behavioural model.
module tb_branch_predict_unit;

  localparam int SW   = 4;
  localparam int SMAX = 15;
  localparam int NENT = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   if_pc;
  logic          pred_taken;
  logic          ex_valid;
  logic [31:0]   ex_pc;
  logic [2:0]    ex_branch_src;
  logic          zero, neg, negu;
  logic          ex_pred_taken;
  logic          ex_taken;
  logic          mispredict;
  logic          mispredict_taken;
  logic          stat_clear;
  logic [SW-1:0] stat_branches;
  logic [SW-1:0] stat_mispredicts;

  int nvec = 0;
  int nerr = 0;

  // Reference state
  int m_ctr [NENT];
  int m_sb, m_sm;
  bit m_mp, m_mpt;

  branch_predict_unit #(
    .ENTRIES(64), .PC_WIDTH(32), .STAT_WIDTH(SW), .INIT_STATE(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch_src(ex_branch_src),
    .zero(zero), .neg(neg), .negu(negu), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .mispredict(mispredict),
    .mispredict_taken(mispredict_taken), .stat_clear(stat_clear),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  function automatic bit dec(int s, bit z, bit n, bit nu);
    case (s)
      1: return z;
      2: return !z;
      3: return n;
      4: return !n || z;
      5: return nu;
      6: return !nu || z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx(logic [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic bit mpred(logic [31:0] pc);
    return m_ctr[idx(pc)] >= 2;
  endfunction

  // Apply one clock edge to the model using the inputs as currently driven.
  task automatic model_edge();
    bit br, t, m;
    int s;
    s = int'(ex_branch_src);
    if (!rst_n) begin
      foreach (m_ctr[i]) m_ctr[i] = 1;
      m_mp = 0; m_mpt = 0; m_sb = 0; m_sm = 0;
      return;
    end
    br = ex_valid && s >= 1 && s <= 6;
    t  = dec(s, zero, neg, negu);
    m  = br && (t != ex_pred_taken);
    m_mp = m;
    if (br) begin
      m_mpt = t;
      if (t) m_ctr[idx(ex_pc)] = (m_ctr[idx(ex_pc)] < 3) ? m_ctr[idx(ex_pc)] + 1 : 3;
      else   m_ctr[idx(ex_pc)] = (m_ctr[idx(ex_pc)] > 0) ? m_ctr[idx(ex_pc)] - 1 : 0;
    end
    if (stat_clear) begin
      m_sb = 0; m_sm = 0;
    end else begin
      if (br) m_sb = (m_sb < SMAX) ? m_sb + 1 : SMAX;
      if (m)  m_sm = (m_sm < SMAX) ? m_sm + 1 : SMAX;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_branch_src = 0; zero = 0; neg = 0; negu = 0;
    ex_pred_taken = 0; stat_clear = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic branch(logic [31:0] pc, int s, bit z, bit pt);
    ex_valid = 1; ex_pc = pc; ex_branch_src = 3'(s);
    zero = z; neg = 0; negu = 0; ex_pred_taken = pt;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h100; pcs[2] = 32'hFC;
    idle();
    rst_n = 0;
    branch(32'h100, 1, 1, 0);
    tick();
    rst_n = 1;
    idle();
    for (int i = 0; i < 3; i++) begin
      if_pc = pcs[i];
      #1;
      nvec++;
      if (pred_taken !== 1'b0) begin
        nerr++;
        $display("FAIL reset_pred pc=%h got %b want 0", if_pc, pred_taken);
      end
    end
    nvec++;
    if (stat_branches !== 0 || stat_mispredicts !== 0) begin
      nerr++;
      $display("FAIL reset_stats got %0d/%0d want 0/0",
               stat_branches, stat_mispredicts);
    end
    nvec++;
    if (mispredict !== 1'b0 || mispredict_taken !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mp got %b/%b want 0/0", mispredict, mispredict_taken);
    end
    // Entry 0x100 must still be weak NT: one taken makes it predict taken.
    branch(32'h100, 1, 1, 0);
    if_pc = 32'h100;
    tick();
    idle();
    #1;
    nvec++;
    if (pred_taken !== 1'b1) begin
      nerr++;
      $display("FAIL reset_entry01 got %b want 1", pred_taken);
    end
  endtask

  task automatic test_train_up();
    int exp_ctr [3];
    exp_ctr[0] = 1; exp_ctr[1] = 2; exp_ctr[2] = 3;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if_pc = 32'h100;
      branch(32'h100, 1, 1, mpred(32'h100));
      #1;
      nvec++;
      if (pred_taken !== (exp_ctr[k] >= 2)) begin
        nerr++;
        $display("FAIL train_pred k=%0d got %b want %b", k, pred_taken,
                 exp_ctr[k] >= 2);
      end
      tick();
      nvec++;
      if (mispredict !== (k == 0) || mispredict_taken !== 1'b1) begin
        nerr++;
        $display("FAIL train_mp k=%0d got %b/%b want %b/1", k, mispredict,
                 mispredict_taken, k == 0);
      end
    end
    idle();
    nvec++;
    if (stat_branches !== 3 || stat_mispredicts !== 1) begin
      nerr++;
      $display("FAIL train_stats got %0d/%0d want 3/1",
               stat_branches, stat_mispredicts);
    end
    nvec++;
    if (m_ctr[idx(32'h100)] != 3 || pred_taken !== 1'b1) begin
      nerr++;
      $display("FAIL train_ctr model=%0d pred=%b want 3/1",
               m_ctr[idx(32'h100)], pred_taken);
    end
  endtask

  task automatic test_conditions();
    int s;
    bit want;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      s = i / 8;
      ex_valid = 1;
      ex_branch_src = 3'(s);
      zero = i[2]; neg = i[1]; negu = i[0];
      ex_pc = $urandom & 32'hFC;
      if_pc = ex_pc;
      ex_pred_taken = 1'($urandom);
      want = dec(s, i[2], i[1], i[0]);
      #1;
      nvec++;
      if (ex_taken !== want) begin
        nerr++;
        $display("FAIL cond src=%0d zn=%b%b%b got %b want %b", s,
                 zero, neg, negu, ex_taken, want);
      end
      tick();
      nvec++;
      if (mispredict !== m_mp || stat_branches !== SW'(m_sb)
          || stat_mispredicts !== SW'(m_sm) || pred_taken !== mpred(if_pc)) begin
        nerr++;
        $display("FAIL cond_state src=%0d got mp=%b sb=%0d sm=%0d pt=%b want %b %0d %0d %b",
                 s, mispredict, stat_branches, stat_mispredicts, pred_taken,
                 m_mp, m_sb, m_sm, mpred(if_pc));
      end
    end
    idle();
  endtask

  task automatic test_alias_bypass();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      branch(32'h100, 1, 1, mpred(32'h100));
      tick();
    end
    if_pc = 32'h200;
    branch(32'h200, 2, 1, 1);
    #1;
    nvec++;
    if (pred_taken !== 1'b1 || ex_taken !== 1'b0) begin
      nerr++;
      $display("FAIL alias_same got pt=%b et=%b want 1/0", pred_taken, ex_taken);
    end
    tick();
    idle();
    nvec++;
    if (pred_taken !== 1'b1 || mispredict !== 1'b1 || mispredict_taken !== 1'b0) begin
      nerr++;
      $display("FAIL alias_next got pt=%b mp=%b mt=%b want 1/1/0",
               pred_taken, mispredict, mispredict_taken);
    end
    branch(32'h300, 2, 1, 1);
    tick();
    idle();
    if_pc = 32'h100;
    #1;
    nvec++;
    if (pred_taken !== 1'b0) begin
      nerr++;
      $display("FAIL alias_down got %b want 0", pred_taken);
    end
  endtask

  task automatic test_stat_saturation();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      branch($urandom, 1, 1, 0);
      tick();
    end
    idle();
    nvec++;
    if (stat_branches !== 15 || stat_mispredicts !== 15) begin
      nerr++;
      $display("FAIL stat_sat got %0d/%0d want 15/15",
               stat_branches, stat_mispredicts);
    end
    branch(32'h40, 1, 1, 0);
    stat_clear = 1;
    tick();
    idle();
    nvec++;
    if (stat_branches !== 0 || stat_mispredicts !== 0 || mispredict !== 1'b1) begin
      nerr++;
      $display("FAIL stat_clear got %0d/%0d mp=%b want 0/0 mp=1",
               stat_branches, stat_mispredicts, mispredict);
    end
  endtask

  task automatic test_reset_midstream();
    int bad;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      branch(32'h10 * (k % 3 + 1), 1, 1, 1);
      tick();
    end
    branch(32'h40, 1, 1, 0);
    tick();
    nvec++;
    if (mispredict !== 1'b1) begin
      nerr++;
      $display("FAIL mid_pre got %b want 1", mispredict);
    end
    rst_n = 0;
    branch(32'h10, 1, 1, 0);
    tick();
    rst_n = 1;
    idle();
    nvec++;
    if (mispredict !== 1'b0 || stat_branches !== 0) begin
      nerr++;
      $display("FAIL mid_rst got mp=%b sb=%0d want 0/0", mispredict, stat_branches);
    end
    bad = 0;
    for (int i = 0; i < NENT; i++) begin
      if_pc = 32'(i * 4);
      #1;
      if (pred_taken !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL mid_table got %0d taken entries want 0", bad);
    end
  endtask

  task automatic test_random();
    int s;
    bit want;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      s = int'($urandom_range(7, 0));
      ex_valid = ($urandom_range(9, 0) < 8);
      ex_branch_src = 3'(s);
      zero = 1'($urandom); neg = 1'($urandom); negu = 1'($urandom);
      ex_pc = $urandom & 32'h3FF;
      if_pc = ($urandom_range(1, 0) == 1) ? ex_pc : ($urandom & 32'h3FF);
      ex_pred_taken = ($urandom_range(1, 0) == 1) ? mpred(ex_pc) : 1'($urandom);
      stat_clear = ($urandom_range(19, 0) == 0);
      want = dec(s, zero, neg, negu);
      #1;
      nvec++;
      if (ex_taken !== want || pred_taken !== mpred(if_pc)) begin
        nerr++;
        $display("FAIL rand_comb k=%0d got et=%b pt=%b want %b %b", k,
                 ex_taken, pred_taken, want, mpred(if_pc));
      end
      tick();
      nvec++;
      if (mispredict !== m_mp || mispredict_taken !== m_mpt
          || stat_branches !== SW'(m_sb) || stat_mispredicts !== SW'(m_sm)
          || pred_taken !== mpred(if_pc)) begin
        nerr++;
        $display("FAIL rand_seq k=%0d got %b %b %0d %0d %b want %b %b %0d %0d %b",
                 k, mispredict, mispredict_taken, stat_branches,
                 stat_mispredicts, pred_taken, m_mp, m_mpt, m_sb, m_sm,
                 mpred(if_pc));
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 0;
    if_pc = 0;
    ex_pc = 0;
    idle();
    test_reset();
    test_train_up();
    test_conditions();
    test_alias_bypass();
    test_stat_saturation();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
